alu_sra_pipe: RTL and testbench

ALU_SRA_PIPE -- requirements
Module: alu_sra_pipe

---
 rtl/alu_sra_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_sra_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sra_pipe.sv
// alu_sra_pipe: two-stage valid/ready ALU with ADD, SUB, signed MAX/MIN,
// arithmetic shift right and PASS. Stage 1 captures operands plus the
// sign-extended sum/difference. Stage 2 captures result, ovf and neg.
module alu_sra_pipe #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             neg
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 state
  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [WIDTH:0]   s1_ext_q;

  // Stage 2 state
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             neg_q;

  // Handshake and next-state terms
  logic             s2_load;
  logic             s1_load;
  logic             use_diff;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   ext_d;
  logic [WIDTH-1:0] sign_fill;
  logic [WIDTH-1:0] sra_shift;
  logic             sra_big;
  logic             ext_ovf;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;

  // S2 can take a new entry when empty or when its current entry leaves now.
  assign s2_load   = !s2_valid_q || out_ready;
  // S1 can take operands when empty or when its entry moves into S2 now.
  assign in_ready  = !rst && (!s1_valid_q || s2_load);
  assign s1_load   = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;

  // MAX/MIN reuse the WIDTH+1-bit difference so the sign is never wrong.
  assign use_diff = (op == OP_SUB) || (op == OP_MAX) || (op == OP_MIN);
  assign a_ext    = {a[WIDTH-1], a};
  assign b_ext    = {b[WIDTH-1], b};
  assign ext_d    = use_diff ? (a_ext - b_ext) : (a_ext + b_ext);

  // Replicated sign bit used when the shift amount covers the whole word.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fill
      assign sign_fill[gi] = s1_a_q[WIDTH-1];
    end
  endgenerate

  assign sra_big   = (s1_b_q >= WIDTH'(WIDTH));
  assign sra_shift = $unsigned($signed(s1_a_q) >>> s1_b_q[SHW-1:0]);
  assign ext_ovf   = s1_ext_q[WIDTH] ^ s1_ext_q[WIDTH-1];

  // Stage 2 result selection from the registered stage 1 contents.
  always_comb begin
    result_d = s1_a_q;
    ovf_d    = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        ovf_d = ext_ovf;
        if (SATURATE && ext_ovf) begin
          result_d = s1_ext_q[WIDTH] ? SAT_NEG : SAT_POS;
        end else begin
          result_d = s1_ext_q[WIDTH-1:0];
        end
      end
      OP_MAX:  result_d = s1_ext_q[WIDTH] ? s1_b_q : s1_a_q;
      OP_MIN:  result_d = s1_ext_q[WIDTH] ? s1_a_q : s1_b_q;
      OP_SRA:  result_d = sra_big ? sign_fill : sra_shift;
      default: result_d = s1_a_q;
    endcase
  end

  // Stage 1 register: empties when its entry advances and nothing new arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ext_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        s1_op_q  <= op;
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_ext_q <= ext_d;
      end
    end
  end

  // Stage 2 register: outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        neg_q    <= result_d[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_sra_pipe.sv
// Directed bench for alu_sra_pipe: 8-bit wrap, 8-bit saturating and
// 16-bit saturating instances with hand-computed expectations.
module tb_alu_sra_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid16, out_ready;
  logic [2:0]  op, op16;
  logic [7:0]  a, b;
  logic [15:0] a16, b16;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [7:0]  res0, res1;
  logic [15:0] res2;
  logic        ovf0, ovf1, ovf2, neg0, neg1, neg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sra_pipe #(.WIDTH(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .op(op),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .ovf(ovf0), .neg(neg0));

  alu_sra_pipe #(.WIDTH(8), .SATURATE(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .ovf(ovf1), .neg(neg1));

  alu_sra_pipe #(.WIDTH(16), .SATURATE(1'b1)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy2), .op(op16),
    .a(a16), .b(b16), .out_valid(ov2), .out_ready(out_ready), .result(res2),
    .ovf(ovf2), .neg(neg2));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One op through both 8-bit instances; result expected at edge N+2.
  task automatic op8(input string tag, input logic [2:0] o, input logic [7:0] xa,
                     input logic [7:0] xb, input logic [7:0] e0, input logic eo0,
                     input logic [7:0] e1, input logic eo1);
    @(negedge clk);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    chk1({tag, ":in_ready"}, rdy0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 'x; a = 'x; b = 'x;
    chk1({tag, ":early_valid"}, ov0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1({tag, ":valid"}, ov0, 1'b1);
    chk8({tag, ":result"}, res0, e0);
    chk1({tag, ":ovf"}, ovf0, eo0);
    chk1({tag, ":neg"}, neg0, e0[7]);
    chk1({tag, ":sat_valid"}, ov1, 1'b1);
    chk8({tag, ":sat_result"}, res1, e1);
    chk1({tag, ":sat_ovf"}, ovf1, eo1);
    chk1({tag, ":sat_neg"}, neg1, e1[7]);
    $display("op8 %s op=%0d a=0x%02h b=0x%02h -> 0x%02h/0x%02h", tag, o, xa, xb, res0, res1);
  endtask

  task automatic op16t(input string tag, input logic [2:0] o, input logic [15:0] xa,
                       input logic [15:0] xb, input logic [15:0] e, input logic eo);
    @(negedge clk);
    op16 = o; a16 = xa; b16 = xb; in_valid16 = 1'b1;
    chk1({tag, ":in_ready"}, rdy2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    chk1({tag, ":early_valid"}, ov2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1({tag, ":valid"}, ov2, 1'b1);
    chk16({tag, ":result"}, res2, e);
    chk1({tag, ":ovf"}, ovf2, eo);
    chk1({tag, ":neg"}, neg2, e[15]);
    $display("op16 %s op=%0d a=0x%04h b=0x%04h -> 0x%04h", tag, o, xa, xb, res2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; op16 = '0; a16 = '0; b16 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst:out_valid", ov0, 1'b0);
    chk8("rst:result", res0, 8'h00);
    chk1("rst:ovf", ovf0, 1'b0);
    chk1("rst:neg", neg0, 1'b0);
    chk1("rst:in_ready", rdy0, 1'b0);
    chk1("rst:out_valid16", ov2, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("post_rst:in_ready", rdy0, 1'b1);
    $display("reset released");

    // Arithmetic, compare, shift and pass vectors
    op8("add_100_50", 3'b000, 8'd100, 8'd50, 8'h96, 1'b1, 8'h7F, 1'b1);
    op8("add_neg_sat", 3'b000, 8'h80, 8'hFF, 8'h7F, 1'b1, 8'h80, 1'b1);
    op8("add_plain", 3'b000, 8'd20, 8'hFB, 8'h0F, 1'b0, 8'h0F, 1'b0);
    op8("max", 3'b010, 8'd100, 8'h9C, 8'h64, 1'b0, 8'h64, 1'b0);
    op8("min", 3'b011, 8'd100, 8'h9C, 8'h9C, 1'b0, 8'h9C, 1'b0);
    op8("sub", 3'b001, 8'd100, 8'h9C, 8'hC8, 1'b1, 8'h7F, 1'b1);
    op8("max_tie", 3'b010, 8'h33, 8'h33, 8'h33, 1'b0, 8'h33, 1'b0);
    op8("min_tie", 3'b011, 8'hC0, 8'hC0, 8'hC0, 1'b0, 8'hC0, 1'b0);
    op8("sra_3", 3'b100, 8'h90, 8'd3, 8'hF2, 1'b0, 8'hF2, 1'b0);
    op8("sra_9", 3'b100, 8'h90, 8'd9, 8'hFF, 1'b0, 8'hFF, 1'b0);
    op8("sra_pos4", 3'b100, 8'h70, 8'd4, 8'h07, 1'b0, 8'h07, 1'b0);
    op8("sra_0", 3'b100, 8'h90, 8'd0, 8'h90, 1'b0, 8'h90, 1'b0);
    op8("pass", 3'b111, 8'hA5, 8'h12, 8'hA5, 1'b0, 8'hA5, 1'b0);

    // 16-bit saturating instance
    op16t("w16_sub", 3'b001, 16'h8000, 16'h0001, 16'h8000, 1'b1);
    op16t("w16_sra", 3'b100, 16'h8000, 16'd15, 16'hFFFF, 1'b0);

    // Five back-to-back ops: op k is ADD (k+1)+1, emerging at step k+2
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk1("b2b:valid", ov0, 1'b1);
        chk8("b2b:result", res0, 8'(c));
        $display("b2b step %0d result 0x%02h", c, res0);
      end else begin
        chk1("b2b:idle", ov0, 1'b0);
      end
      if (c < 5) begin
        op = 3'b000; a = 8'(c + 1); b = 8'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
    end

    // Stall: out_ready low for four edges while three ops are offered
    @(negedge clk);
    out_ready = 1'b0;
    op = 3'b000; a = 8'd10; b = 8'd1; in_valid = 1'b1;
    chk1("stall:rdy_a", rdy0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("stall:rdy_b", rdy0, 1'b1);
    a = 8'd20;
    @(posedge clk);
    @(negedge clk);
    chk1("stall:valid0", ov0, 1'b1);
    chk8("stall:res0", res0, 8'h0B);
    chk1("stall:rdy_low0", rdy0, 1'b0);
    a = 8'd30;
    @(posedge clk);
    @(negedge clk);
    chk1("stall:valid1", ov0, 1'b1);
    chk8("stall:res1", res0, 8'h0B);
    chk1("stall:rdy_low1", rdy0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1("stall:valid2", ov0, 1'b1);
    chk8("stall:res2", res0, 8'h0B);
    chk1("stall:rdy_low2", rdy0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk1("stall:rdy_release", rdy0, 1'b1);
    $display("stall released, result held 0x%02h", res0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("drain:valid_b", ov0, 1'b1);
    chk8("drain:res_b", res0, 8'h15);
    @(posedge clk);
    @(negedge clk);
    chk1("drain:valid_c", ov0, 1'b1);
    chk8("drain:res_c", res0, 8'h1F);
    @(posedge clk);
    @(negedge clk);
    chk1("drain:empty", ov0, 1'b0);
    $display("stall sequence drained");

    // Reset with two ops in flight
    op = 3'b000; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'd2; b = 8'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("midrst:rdy", rdy0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1("midrst:valid", ov0, 1'b0);
    chk8("midrst:result", res0, 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("midrst:no_ghost", ov0, 1'b0);
    end
    $display("mid-flight reset flushed");
    op8("post_rst_add", 3'b000, 8'd7, 8'd8, 8'h0F, 1'b0, 8'h0F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
